lcd_bitmap_fetch: RTL
=====================

# lcd_bitmap_fetch

Streaming reader for the LCD bitmap ROMs (the single-port, 1-cycle-latency sign/sprite ROMs). On a `start` pulse it walks a rectangular window of a row-major bitmap, drives ROM addresses, absorbs the ROM read latency, and presents pixels to the LCD draw logic over a valid/ready stream with row and frame markers. It sits between the BlockROM instances and the LCD pixel writer, and replaces ad-hoc address counters in the draw FSMs.

## Interface
- `ADDR_WIDTH`, 17: ROM address width; also width of `base` and `stride`.
- `DATA_WIDTH`, 1: bits per pixel, equal to the ROM data width.
- `DIM_WIDTH`, 9: width of the `width` and `height` fields.

- `clk`  in  1: single clock. The ROM uses the same clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request. Sampled only in IDLE; ignored otherwise.
- `base`  in  ADDR_WIDTH: address of the window's top-left pixel. Sampled with `start`.
- `stride`  in  ADDR_WIDTH: address distance between rows. Sampled with `start`.
- `width`  in  DIM_WIDTH: pixels per row. Sampled with `start`.
- `height`  in  DIM_WIDTH: number of rows. Sampled with `start`.
- `rom_addr`  out  ADDR_WIDTH: ROM address. Registered.
- `rom_data`  in  DATA_WIDTH: ROM output. Valid in the cycle after the address is issued.
- `pix_valid`  out  1: a pixel is available.
- `pix_ready`  in  1: consumer accepts the pixel.
- `pix_data`  out  DATA_WIDTH: pixel value.
- `pix_eol`  out  1: pixel is the last of its row.
- `pix_last`  out  1: pixel is the last of the window. Implies `pix_eol`.
- `busy`  out  1: high from the `start` acceptance until `done`.
- `done`  out  1: one-cycle pulse after the last pixel has been accepted.

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE + `start`: latch the parameters and set `row_base = base`, `col = 0`, `row = 0`.
    - If `width == 0` or `height == 0`, go straight to DRAIN. No reads are issued.
    - Otherwise go to RUN.
  - RUN issues one read per cycle while credit is available:
    - Address = `row_base + col`, computed modulo 2^ADDR_WIDTH (wraps, no error).
    - After `col == width-1`: set `col = 0`, `row_base += stride`, `row += 1`.
    - After the read for (`height-1`, `width-1`) has issued, go to DRAIN.
  - DRAIN: wait until the in-flight read has landed and the buffer is empty. Then pulse `done` and go to IDLE.
- Each issued read carries `eol` and `last` tags through a 1-stage tag pipe aligned with the ROM latency.
- Output buffer: a 2-entry show-ahead FIFO holding {data, eol, last}.
  - `pix_valid` = FIFO not empty.
  - A pop occurs when `pix_valid & pix_ready`.
- Credit rule: issue a read only when `fifo_count + inflight - pop < 2`. Under this rule the FIFO never overflows, and a continuously ready consumer gets 1 pixel/cycle.
- `rom_addr` holds its last value when no read is issued (no spurious-address side effects).
- Reset (asynchronous, at any time, including mid-window):
  - State returns to IDLE; FIFO, in-flight flag and counters are cleared.
  - Outputs: `rom_addr=0`, `pix_valid=0`, `pix_data=0`, `pix_eol=0`, `pix_last=0`, `busy=0`, `done=0`.
  - Pixels not yet accepted are discarded.
- `start` while `busy` is ignored. Parameters changing while busy have no effect.

## Timing
- `start` is sampled at edge E0:
  - `busy=1` and `rom_addr=base` from E0.
  - Data is captured by the ROM at E1 and written to the FIFO at E2.
  - `pix_valid=1` from E2 (first pixel 3 cycles after the start edge, counting E0).
- Steady state with `pix_ready=1`: one pixel per cycle. A W×H window takes W·H + 3 cycles from `start` to `done`.
- With `pix_ready=0`: at most 2 pixels are buffered. Issue stalls in the same cycle the credit reaches 0 and resumes in the cycle after a pop.
- `done` is asserted the cycle after the acceptance of the `pix_last` pixel. `busy` falls on the same edge.
- A new `start` is accepted in the cycle `done` is high (state is already IDLE).
- Zero-sized window: `done` pulses 1 cycle after `start`, with no `pix_valid`.

## Structure
- Shared `lcd_pkg`:
  - FIFO entry struct {data, eol, last}.
  - State enum.
  - `FETCH_FIFO_DEPTH = 2`.
- Sub-module `lcd_fetch_fifo`: 2-entry show-ahead FIFO with count output. It is reusable by other LCD stream stages.
- The ROM is external. The top level instantiates BlockROM next to `lcd_bitmap_fetch`.

## Test plan
- Full-throughput window: base=0x100, stride=16, width=4, height=3, `pix_ready=1`, with a ROM model.
  - Addresses issued: 0x100–0x103, 0x110–0x113, 0x120–0x123.
  - 12 pixels are consecutive and match the model.
  - `pix_eol` on pixels 4, 8 and 12; `pix_last` on pixel 12 only.
  - `done` at cycle 15.
- Backpressure: same window, `pix_ready` random at 30%.
  - No pixel is lost or duplicated; order is preserved.
  - FIFO count never exceeds 2.
  - `pix_data` is stable while valid and not ready.
- Address wrap: base=0x1FFFE, stride=1, width=4, height=1 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Degenerate cases:
  - width=0, height=5 → `done` 1 cycle after `start`, no `pix_valid`, `rom_addr` unchanged.
  - width=1, height=1 → a single pixel with `eol=last=1`.
- Back-to-back requests:
  - `start` while busy is ignored.
  - `start` in the `done` cycle launches the second window with no idle gap.
- Reset mid-window: assert `rst_n=0` after pixel 5 of 12.
  - All outputs return to their reset values asynchronously.
  - A new `start` after release fetches its window from its first pixel, with no stale FIFO contents.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD bitmap stream stages
package lcd_pkg;

    localparam int FETCH_FIFO_DEPTH = 2;
    localparam int LCD_DATA_WIDTH   = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [LCD_DATA_WIDTH-1:0] data;
        logic                      eol;
        logic                      last;
    } fetch_entry_t;

endpackage

// File: rtl/lcd_fetch_fifo.sv
// rtl/lcd_fetch_fifo.sv - 2-entry show-ahead FIFO of pixel entries with occupancy count
module lcd_fetch_fifo
    import lcd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [FETCH_FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign full    = count == 2'(FETCH_FIFO_DEPTH);
    assign do_pop  = pop && (count != 2'd0);
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = (count != 2'd0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/lcd_bitmap_fetch.sv
// rtl/lcd_bitmap_fetch.sv - walks a bitmap window in a 1-cycle ROM and streams its pixels
module lcd_bitmap_fetch
    import lcd_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = LCD_DATA_WIDTH,
    parameter int DIM_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_eol,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] row_base, stride_q;
    logic [DIM_WIDTH-1:0]  col, row, width_q, height_q;
    logic                  a_valid, a_eol, a_last;
    logic                  b_valid, b_eol, b_last;
    logic [1:0]            fifo_count;
    fetch_entry_t          head;
    logic                  idle, zero_size, pop, b_push, credit_ok, issue;
    logic                  col_end, row_end;
    logic [ADDR_WIDTH-1:0] cur_base, cur_stride;
    logic [DIM_WIDTH-1:0]  cur_col, cur_row, cur_w, cur_h;

    assign idle      = state == ST_IDLE;
    assign zero_size = (width == '0) || (height == '0);
    assign pop       = pix_valid && pix_ready;
    assign b_push    = b_valid && ((fifo_count < 2'(FETCH_FIFO_DEPTH)) || pop);
    assign credit_ok = ({1'b0, fifo_count} + {2'b0, b_valid}) < (3'(FETCH_FIFO_DEPTH) + {2'b0, pop});
    assign issue     = idle ? (start && !zero_size) : ((state == ST_RUN) && credit_ok);

    // The first read goes out on the start edge, straight from the request inputs.
    assign cur_base   = idle ? base   : row_base;
    assign cur_stride = idle ? stride : stride_q;
    assign cur_col    = idle ? '0     : col;
    assign cur_row    = idle ? '0     : row;
    assign cur_w      = idle ? width  : width_q;
    assign cur_h      = idle ? height : height_q;
    assign col_end    = cur_col == (cur_w - DIM_WIDTH'(1));
    assign row_end    = cur_row == (cur_h - DIM_WIDTH'(1));

    lcd_fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (b_push),
        .push_entry ('{data: rom_data, eol: b_eol, last: b_last}),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign pix_valid = fifo_count != 2'd0;
    assign pix_data  = head.data;
    assign pix_eol   = head.eol;
    assign pix_last  = head.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            row_base <= '0;
            stride_q <= '0;
            col      <= '0;
            row      <= '0;
            width_q  <= '0;
            height_q <= '0;
            a_valid  <= 1'b0;
            a_eol    <= 1'b0;
            a_last   <= 1'b0;
            b_valid  <= 1'b0;
            b_eol    <= 1'b0;
            b_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            a_valid <= issue;
            // A blocked read parks in the ROM output: no new issue happens while it waits,
            // so the unchanged rom_addr keeps re-reading the same word.
            if (!(b_valid && !b_push)) begin
                b_valid <= a_valid;
                b_eol   <= a_eol;
                b_last  <= a_last;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        width_q  <= width;
                        height_q <= height;
                        stride_q <= stride;
                        busy     <= 1'b1;
                        state    <= zero_size ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!a_valid && !b_valid &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: ;
            endcase
            if (issue) begin
                rom_addr <= cur_base + ADDR_WIDTH'(cur_col);
                a_eol    <= col_end;
                a_last   <= col_end && row_end;
                if (col_end) begin
                    col      <= '0;
                    row      <= cur_row + DIM_WIDTH'(1);
                    row_base <= cur_base + cur_stride;
                    if (row_end) begin
                        state <= ST_DRAIN;
                    end
                end else begin
                    col      <= cur_col + DIM_WIDTH'(1);
                    row      <= cur_row;
                    row_base <= cur_base;
                end
            end
        end
    end

endmodule
